// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: per-channel OFF/DIM/BLINK/BREATHE modes
// sharing one free-running PWM counter, reconfigured through a valid/ready port.
module led_pattern_gen #(
  parameter int  NUM_CH         = 3,
  parameter int  CNT_W          = 25,
  parameter int  PWM_W          = 8,
  parameter int  DEFAULT_PERIOD = 2**24,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [PWM_W-1:0]  cfg_duty,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] led
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_DIM     = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_t;

  localparam logic [PWM_W-1:0] LEVEL_MAX  = {PWM_W{1'b1}};
  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);

  mode_t             mode_q     [NUM_CH];
  mode_t             mode_d     [NUM_CH];
  logic [CNT_W-1:0]  period_q   [NUM_CH];
  logic [CNT_W-1:0]  period_d   [NUM_CH];
  logic [CNT_W-1:0]  cnt_q      [NUM_CH];
  logic [CNT_W-1:0]  cnt_d      [NUM_CH];
  logic [CNT_W-1:0]  last_cnt   [NUM_CH];
  logic [PWM_W-1:0]  duty_q     [NUM_CH];
  logic [PWM_W-1:0]  duty_d     [NUM_CH];
  logic [PWM_W-1:0]  level_q    [NUM_CH];
  logic [PWM_W-1:0]  level_d    [NUM_CH];
  logic              dir_down_q [NUM_CH];
  logic              dir_down_d [NUM_CH];
  logic              toggle_q   [NUM_CH];
  logic              toggle_d   [NUM_CH];
  logic              step       [NUM_CH];
  logic [NUM_CH-1:0] led_d;
  logic [PWM_W-1:0]  pwm_cnt;
  logic              accept;
  logic              ch_bad;

  // A config accept on a channel replaces that channel's whole state, so any
  // step event computed in the same cycle is simply overwritten.
  always_comb begin
    accept = cfg_valid & cfg_ready;
    ch_bad = ({1'b0, cfg_ch} >= (CH_W+1)'(NUM_CH));
    led_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mode_d[i]     = mode_q[i];
      period_d[i]   = period_q[i];
      duty_d[i]     = duty_q[i];
      cnt_d[i]      = cnt_q[i];
      level_d[i]    = level_q[i];
      dir_down_d[i] = dir_down_q[i];
      toggle_d[i]   = toggle_q[i];
      last_cnt[i]   = (period_q[i] == '0) ? '0 : period_q[i] - CNT_W'(1);
      step[i]       = (mode_q[i] != MODE_OFF) && (cnt_q[i] == last_cnt[i]);

      case (mode_q[i])
        MODE_DIM:     led_d[i] = (pwm_cnt < duty_q[i]);
        MODE_BLINK:   led_d[i] = toggle_q[i];
        MODE_BREATHE: led_d[i] = (pwm_cnt < level_q[i]);
        default:      led_d[i] = 1'b0;
      endcase

      if (mode_q[i] == MODE_OFF || step[i])
        cnt_d[i] = '0;
      else
        cnt_d[i] = cnt_q[i] + CNT_W'(1);

      if (step[i] && mode_q[i] == MODE_BLINK)
        toggle_d[i] = ~toggle_q[i];

      // Direction flips in the same update that reaches an end of the ramp.
      if (step[i] && mode_q[i] == MODE_BREATHE) begin
        if (!dir_down_q[i]) begin
          if (level_q[i] != LEVEL_MAX) level_d[i] = level_q[i] + PWM_W'(1);
          if (level_q[i] >= LEVEL_MAX - PWM_W'(1)) dir_down_d[i] = 1'b1;
        end else begin
          if (level_q[i] != '0) level_d[i] = level_q[i] - PWM_W'(1);
          if (level_q[i] <= PWM_W'(1)) dir_down_d[i] = 1'b0;
        end
      end

      if (accept && !ch_bad && cfg_ch == CH_W'(i)) begin
        mode_d[i]     = mode_t'(cfg_mode);
        period_d[i]   = cfg_period;
        duty_d[i]     = cfg_duty;
        cnt_d[i]      = '0;
        level_d[i]    = '0;
        dir_down_d[i] = 1'b0;
        toggle_d[i]   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt   <= '0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      led       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]     <= MODE_BLINK;
        period_q[i]   <= RST_PERIOD;
        duty_q[i]     <= LEVEL_MAX;
        cnt_q[i]      <= '0;
        level_q[i]    <= '0;
        dir_down_q[i] <= 1'b0;
        toggle_q[i]   <= 1'b0;
      end
    end else begin
      pwm_cnt   <= pwm_cnt + PWM_W'(1);
      cfg_ready <= 1'b1;
      cfg_err   <= accept & ch_bad;
      led       <= led_d;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]     <= mode_d[i];
        period_q[i]   <= period_d[i];
        duty_q[i]     <= duty_d[i];
        cnt_q[i]      <= cnt_d[i];
        level_q[i]    <= level_d[i];
        dir_down_q[i] <= dir_down_d[i];
        toggle_q[i]   <= toggle_d[i];
      end
    end
  end

endmodule
